// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner codes, requester IDs
// and the saturating-increment helper used by the optional performance counters.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_CPU = 2'b01,
        GNT_DMA = 2'b10
    } arb_state_e;

    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    localparam int unsigned PERF_W = 32;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != {PERF_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating beat/stall counters for the memory-port arbiter; only instantiated when
// MEM_PORT_ARBITER_PERF_EN is defined.
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cpu_ack,
    input  logic              i_dma_ack,
    input  logic              i_cpu_stall,
    output logic [PERF_W-1:0] o_cpu_beats,
    output logic [PERF_W-1:0] o_dma_beats,
    output logic [PERF_W-1:0] o_cpu_stall_cycles
);

    logic [PERF_W-1:0] r_cpu_beats;
    logic [PERF_W-1:0] r_dma_beats;
    logic [PERF_W-1:0] r_cpu_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_beats        <= '0;
            r_dma_beats        <= '0;
            r_cpu_stall_cycles <= '0;
        end else begin
            r_cpu_beats        <= sat_inc(r_cpu_beats, i_cpu_ack);
            r_dma_beats        <= sat_inc(r_dma_beats, i_dma_ack);
            r_cpu_stall_cycles <= sat_inc(r_cpu_stall_cycles, i_cpu_stall);
        end
    end

    assign o_cpu_beats        = r_cpu_beats;
    assign o_dma_beats        = r_dma_beats;
    assign o_cpu_stall_cycles = r_cpu_stall_cycles;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU datapath and a DMA/loader port, with
// bounded locked DMA bursts. Define MEM_PORT_ARBITER_PERF_EN to add perf counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    input  logic          dma_lock,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]   perf_cpu_beats,
    output logic [31:0]   perf_dma_beats,
    output logic [31:0]   perf_cpu_stall_cycles
`endif
);

    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_e    r_state;
    req_id_e       r_last_gnt;
    logic [BW-1:0] r_burst_cnt;
    logic [1:0]    r_owner;

    logic w_cpu_gnt;
    logic w_dma_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IDLE;
            r_last_gnt  <= REQ_DMA;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // On a tie the requester that did not win last time goes first.
                    if (cpu_req && (!dma_req || (r_last_gnt == REQ_DMA))) begin
                        r_state <= GNT_CPU;
                        r_owner <= OWN_CPU;
                    end else if (dma_req) begin
                        r_state     <= GNT_DMA;
                        r_owner     <= OWN_DMA;
                        r_burst_cnt <= '0;
                    end
                end
                GNT_CPU: begin
                    r_last_gnt <= REQ_CPU;
                    r_state    <= IDLE;
                    r_owner    <= OWN_IDLE;
                end
                GNT_DMA: begin
                    r_last_gnt <= REQ_DMA;
                    if (dma_lock && dma_req && (r_burst_cnt < BURST_LAST)) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_owner <= OWN_IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWN_IDLE;
                end
            endcase
        end
    end

    assign w_cpu_gnt = (r_state == GNT_CPU);
    assign w_dma_gnt = (r_state == GNT_DMA);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (w_cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (w_dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end
        // Kill an in-flight write the instant reset rises so it never commits.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    assign cpu_ack   = w_cpu_gnt;
    assign dma_ack   = w_dma_gnt;
    assign cpu_rdata = w_cpu_gnt ? mem_rdata : '0;
    assign dma_rdata = w_dma_gnt ? mem_rdata : '0;
    assign cpu_stall = cpu_req & ~w_cpu_gnt;
    assign owner     = r_owner;

`ifdef MEM_PORT_ARBITER_PERF_EN
    mem_arb_perf u_perf (
        .clk                (clk),
        .reset              (reset),
        .i_cpu_ack          (cpu_ack),
        .i_dma_ack          (dma_ack),
        .i_cpu_stall        (cpu_stall),
        .o_cpu_beats        (perf_cpu_beats),
        .o_dma_beats        (perf_dma_beats),
        .o_cpu_stall_cycles (perf_cpu_stall_cycles)
    );
`endif

endmodule
